// File: rtl/noc_pkg.sv
// Shared NoC definitions: router port geometry, injection arbiter states and
// the credit counter sizing helper.
package noc_pkg;

  localparam int FLIT_W           = 20;
  localparam int ROUTER_BUF_DEPTH = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Counter must hold every value from 0 up to and including the buffer depth.
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin priority selector: first requester at or above
// the pointer wins, wrapping modulo N.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one router injection port among
// NUM_SRC sources, with credit-based flow control toward the router buffer.
module noc_inject_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int FLIT_W    = noc_pkg::FLIT_W,
  parameter int BUF_DEPTH = noc_pkg::ROUTER_BUF_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SRC*FLIT_W-1:0]        src_flit,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC-1:0]               src_last,
  output logic [NUM_SRC-1:0]               src_ready,
  output logic [FLIT_W-1:0]                inject,
  output logic                             inject_valid,
  input  logic                             credit_in,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   credits,
  output logic                             lock_active,
  output logic                             credit_err
);

  import noc_pkg::*;

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = cred_w(BUF_DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(BUF_DEPTH);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic [FLIT_W-1:0] inject_q, inject_d;
  logic              inject_valid_q, inject_valid_d;
  logic              err_q, err_d;

  logic [NUM_SRC-1:0] rr_grant;
  logic [IW-1:0]      rr_idx;
  logic               rr_any;

  logic [IW-1:0]     sel_idx;
  logic              sel_req;
  logic              sel_last;
  logic [FLIT_W-1:0] sel_flit;
  logic              accept;

  rr_select #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_rr (
    .req_i   (src_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  // While locked only the owner is eligible; everyone else stalls.
  always_comb begin
    sel_idx   = (state_q == ARB_LOCKED) ? owner_q : rr_idx;
    sel_req   = (state_q == ARB_LOCKED) ? src_valid[owner_q] : rr_any;
    accept    = !rst && sel_req && (credits_q != '0);
    sel_flit  = src_flit[sel_idx*FLIT_W +: FLIT_W];
    sel_last  = src_last[sel_idx];
    src_ready = '0;
    if (accept) begin
      src_ready = (state_q == ARB_LOCKED) ? (NUM_SRC'(1) << owner_q) : rr_grant;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    credits_d      = credits_q;
    inject_d       = inject_q;
    inject_valid_d = 1'b0;
    err_d          = err_q;

    if (accept) begin
      inject_d       = sel_flit;
      inject_valid_d = 1'b1;
      if (sel_last) begin
        state_d = ARB_IDLE;
        ptr_d   = (sel_idx == IW'(NUM_SRC - 1)) ? '0 : sel_idx + 1'b1;
      end else begin
        state_d = ARB_LOCKED;
        owner_d = sel_idx;
      end
    end

    case ({accept, credit_in})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CRED_MAX) err_d = 1'b1;
        else                       credits_d = credits_q + 1'b1;
      end
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      owner_q        <= '0;
      ptr_q          <= '0;
      credits_q      <= CRED_MAX;
      inject_q       <= '0;
      inject_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      ptr_q          <= ptr_d;
      credits_q      <= credits_d;
      inject_q       <= inject_d;
      inject_valid_q <= inject_valid_d;
      err_q          <= err_d;
    end
  end

  assign inject       = inject_q;
  assign inject_valid = inject_valid_q;
  assign credits      = credits_q;
  assign lock_active  = (state_q == ARB_LOCKED);
  assign credit_err   = err_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Scoreboard bench for noc_inject_arbiter: directed scenarios followed by
// randomized traffic checked against a packet-level reference model.
module tb_noc_inject_arbiter;

  localparam int N  = 4;
  localparam int FW = 20;
  localparam int BD = 4;

  logic              clk;
  logic              rst;
  logic [N*FW-1:0]   src_flit;
  logic [N-1:0]      src_valid;
  logic [N-1:0]      src_last;
  logic [N-1:0]      src_ready;
  logic [FW-1:0]     inject;
  logic              inject_valid;
  logic              credit_in;
  logic [2:0]        credits;
  logic              lock_active;
  logic              credit_err;

  noc_inject_arbiter #(
    .NUM_SRC   (N),
    .FLIT_W    (FW),
    .BUF_DEPTH (BD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_flit     (src_flit),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .inject       (inject),
    .inject_valid (inject_valid),
    .credit_in    (credit_in),
    .credits      (credits),
    .lock_active  (lock_active),
    .credit_err   (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] flit;
    int            stamp;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_acc = -1;

  // Reference model: packet-level state kept as plain integers.
  int m_cred   = BD;
  int m_ptr    = 0;
  int m_owner  = 0;
  bit m_locked = 1'b0;
  bit m_err    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int predict();
    if (rst) return -1;
    if (m_cred == 0) return -1;
    if (m_locked) return src_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (src_valid[j]) return j;
    end
    return -1;
  endfunction

  // One clock cycle: check the combinational grant, then advance the model.
  task automatic step();
    int idx;
    logic [N-1:0] exp_rdy;
    exp_t e;
    #1;
    idx     = predict();
    exp_rdy = (idx >= 0) ? (N'(1) << idx) : '0;
    chk("src_ready", 32'(src_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_cred = BD; m_ptr = 0; m_owner = 0; m_locked = 1'b0; m_err = 1'b0;
    end else begin
      if (idx >= 0) begin
        e.flit  = src_flit[idx*FW +: FW];
        e.stamp = cyc;
        q.push_back(e);
        if (src_last[idx]) begin
          m_locked = 1'b0;
          m_ptr    = (idx + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_owner  = idx;
        end
      end
      if (idx >= 0 && !credit_in) m_cred--;
      else if (idx < 0 && credit_in) begin
        if (m_cred == BD) m_err = 1'b1;
        else              m_cred++;
      end
    end
    last_acc = idx;
    cyc++;
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a flit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (inject_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL inject_unexpected: got flit %0h expected no flit (cycle %0d)", inject, cyc);
        end else begin
          e = q.pop_front();
          chk("inject_flit", 32'(inject), 32'(e.flit));
          chk("inject_latency", 32'(cyc), 32'(e.stamp + 1));
        end
      end else if (q.size() > 0) begin
        e = q.pop_front();
        checks++; failures++;
        $display("FAIL inject_missing: got inject_valid=%b expected flit %0h (cycle %0d)", inject_valid, e.flit, cyc);
      end
      chk("credits", 32'(credits), 32'(m_cred));
      chk("lock_active", 32'(lock_active), 32'(m_locked));
      chk("credit_err", 32'(credit_err), 32'(m_err));
    end
  end

  task automatic idle_inputs();
    src_flit  = '0;
    src_valid = '0;
    src_last  = '0;
    credit_in = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [FW-1:0] f, input logic v, input logic l);
    src_flit[i*FW +: FW] = f;
    src_valid[i]         = v;
    src_last[i]          = l;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int len_rem[N];
  int seq[N];
  int cnt;
  int p;
  logic [FW-1:0] pkt0[3];

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    rst = 1'b0;

    // Reset then idle
    chk("reset_inject", 32'(inject), 32'h0);
    chk("reset_valid", 32'(inject_valid), 32'h0);
    for (int n = 0; n < 10; n++) step();
    chk("idle_credits", 32'(credits), 32'd4);
    chk("idle_valid", 32'(inject_valid), 32'h0);

    // Round-robin fairness with single-flit packets
    do_reset();
    credit_in = 1'b1;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < N; i++) set_src(i, {4'(i), 16'(n)}, 1'b1, 1'b1);
      step();
      chk("rr_order", 32'(last_acc), 32'(n % N));
    end

    // Packet lock: src1 waits for all of src0's packet
    do_reset();
    pkt0[0] = 20'h10001; pkt0[1] = 20'h10002; pkt0[2] = 20'h10003;
    p = 0;
    set_src(1, 20'h20001, 1'b1, 1'b1);
    for (int n = 0; n < 5; n++) begin
      if (p < 3) set_src(0, pkt0[p], 1'b1, (p == 2));
      else       set_src(0, '0, 1'b0, 1'b0);
      step();
      chk("lock_order", 32'(last_acc), (n < 3) ? 32'd0 : (n == 3) ? 32'd1 : 32'hFFFF_FFFF);
      if (last_acc == 0) p++;
      if (last_acc == 1) set_src(1, '0, 1'b0, 1'b0);
    end

    // Credit exhaustion mid-packet
    do_reset();
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      set_src(2, {4'd2, 16'(cnt)}, 1'b1, (cnt == 5));
      step();
      if (last_acc == 2) cnt++;
    end
    chk("exhaust_count", 32'(cnt), 32'd4);
    chk("exhaust_credits", 32'(credits), 32'd0);
    chk("exhaust_lock", 32'(lock_active), 32'd1);
    set_src(2, {4'd2, 16'(cnt)}, 1'b1, 1'b0);
    credit_in = 1'b1;
    step();
    chk("credit_same_cycle", 32'(last_acc), 32'hFFFF_FFFF);
    credit_in = 1'b0;
    step();
    chk("credit_next_cycle", 32'(last_acc), 32'd2);

    // Simultaneous accept + credit, then overflow
    do_reset();
    for (int n = 0; n < 2; n++) begin
      set_src(0, {4'd0, 16'(n)}, 1'b1, 1'b1);
      step();
    end
    credit_in = 1'b1;
    set_src(0, 20'h0_00AA, 1'b1, 1'b1);
    step();
    chk("simul_credits", 32'(credits), 32'd2);
    set_src(0, '0, 1'b0, 1'b0);
    step();
    step();
    chk("refill_credits", 32'(credits), 32'd4);
    chk("refill_err", 32'(credit_err), 32'd0);
    step();
    chk("overflow_credits", 32'(credits), 32'd4);
    chk("overflow_err", 32'(credit_err), 32'd1);
    credit_in = 1'b0;
    for (int n = 0; n < 3; n++) step();
    chk("err_sticky", 32'(credit_err), 32'd1);

    // Reset mid-packet
    do_reset();
    set_src(3, 20'h30001, 1'b1, 1'b0);
    step();
    chk("mid_first", 32'(last_acc), 32'd3);
    set_src(3, 20'h30002, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_lock", 32'(lock_active), 32'd0);
    chk("mid_credits", 32'(credits), 32'd4);
    chk("mid_valid", 32'(inject_valid), 32'd0);
    for (int i = 0; i < N; i++) set_src(i, {4'(i), 16'hBEEF}, 1'b1, 1'b1);
    step();
    chk("mid_restart", 32'(last_acc), 32'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < N; i++) begin
      len_rem[i] = 0;
      seq[i]     = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (len_rem[i] == 0) len_rem[i] = $urandom_range(1, 4);
        set_src(i, {4'(i), 16'(seq[i])}, ($urandom_range(0, 3) != 0), (len_rem[i] == 1));
      end
      credit_in = ($urandom_range(0, 9) < 4);
      rst       = ($urandom_range(0, 499) == 0);
      step();
      if (last_acc >= 0) begin
        seq[last_acc]++;
        len_rem[last_acc]--;
      end
    end
    rst = 1'b0;
    idle_inputs();
    step();
    step();
    chk("drain", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
